// File: rtl/rx_controller.sv
// rx_controller: parses the UART RX byte stream into write, read and ALU
// command frames and presents each command with a valid/ready handshake.
module rx_controller #(
    parameter int unsigned                DATA_WIDTH  = 8,
    parameter int unsigned                TIMEOUT     = 1024,
    parameter logic [DATA_WIDTH-1:0]      RF_WR_CMD   = 8'hAA,
    parameter logic [DATA_WIDTH-1:0]      RF_RD_CMD   = 8'hBB,
    parameter logic [DATA_WIDTH-1:0]      ALU_OP_CMD  = 8'hCC,
    parameter logic [DATA_WIDTH-1:0]      ALU_NOP_CMD = 8'hDD,
    parameter logic [DATA_WIDTH-1:0]      OPA_ADDR    = 8'h00,
    parameter logic [DATA_WIDTH-1:0]      OPB_ADDR    = 8'h01
) (
    input  logic                  RXCont_CLK,
    input  logic                  RXCont_RST,
    input  logic [DATA_WIDTH-1:0] RXCont_P_Data,
    input  logic                  RXCont_Data_Valid,
    input  logic                  RXCont_Ready,
    output logic [2:0]            RXCont_command,
    output logic [DATA_WIDTH-1:0] RXCont_Addr,
    output logic [DATA_WIDTH-1:0] RXCont_Pdata,
    output logic                  RXCont_Cmd_Valid,
    output logic                  RXCont_Frame_Err
);

    localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);

    localparam logic [2:0] CMD_NONE = 3'b000;
    localparam logic [2:0] CMD_WR   = 3'b001;
    localparam logic [2:0] CMD_RD   = 3'b010;
    localparam logic [2:0] CMD_OPND = 3'b011;
    localparam logic [2:0] CMD_ALU  = 3'b100;

    typedef enum logic [2:0] {
        IDLE, WR_ADDR, WR_DATA, RD_ADDR, OP_A, OP_B, ALU_FUN, PEND
    } state_t;

    state_t                state;
    state_t                eff_state;
    logic [DATA_WIDTH-1:0] wr_addr;
    logic [CW-1:0]         tmo_cnt;
    logic                  cmd_accept;
    logic                  cmd_blocked;
    logic                  tmo_active;

    assign cmd_accept  = RXCont_Cmd_Valid & RXCont_Ready;
    // A command still pending after this edge: any new byte is an overrun.
    assign cmd_blocked = RXCont_Cmd_Valid & ~RXCont_Ready;
    // Acceptance in PEND frees the FSM this cycle, so a same-cycle byte starts a new frame.
    assign eff_state   = (state == PEND && cmd_accept) ? IDLE : state;
    assign tmo_active  = (state != IDLE) && (state != PEND) && !RXCont_Cmd_Valid;

    // Frame FSM with registered command outputs, handshake and inter-byte timeout.
    always_ff @(posedge RXCont_CLK or negedge RXCont_RST) begin
        if (!RXCont_RST) begin
            state            <= IDLE;
            wr_addr          <= '0;
            tmo_cnt          <= '0;
            RXCont_command   <= CMD_NONE;
            RXCont_Addr      <= '0;
            RXCont_Pdata     <= '0;
            RXCont_Cmd_Valid <= 1'b0;
            RXCont_Frame_Err <= 1'b0;
        end else begin
            RXCont_Frame_Err <= 1'b0;

            if (cmd_accept) begin
                RXCont_Cmd_Valid <= 1'b0;
                RXCont_command   <= CMD_NONE;
                RXCont_Addr      <= '0;
                RXCont_Pdata     <= '0;
                if (state == PEND) begin
                    state <= IDLE;
                end
            end

            if (RXCont_Data_Valid) begin
                tmo_cnt <= '0;
                if (cmd_blocked) begin
                    // Drop the byte, keep the pending command, abort the frame.
                    RXCont_Frame_Err <= 1'b1;
                    state            <= PEND;
                end else begin
                    case (eff_state)
                        IDLE: begin
                            if (RXCont_P_Data == RF_WR_CMD) begin
                                state <= WR_ADDR;
                            end else if (RXCont_P_Data == RF_RD_CMD) begin
                                state <= RD_ADDR;
                            end else if (RXCont_P_Data == ALU_OP_CMD) begin
                                state <= OP_A;
                            end else if (RXCont_P_Data == ALU_NOP_CMD) begin
                                state <= ALU_FUN;
                            end else begin
                                state            <= IDLE;
                                RXCont_Frame_Err <= 1'b1;
                            end
                        end
                        WR_ADDR: begin
                            wr_addr <= RXCont_P_Data;
                            state   <= WR_DATA;
                        end
                        WR_DATA: begin
                            RXCont_command   <= CMD_WR;
                            RXCont_Addr      <= wr_addr;
                            RXCont_Pdata     <= RXCont_P_Data;
                            RXCont_Cmd_Valid <= 1'b1;
                            state            <= PEND;
                        end
                        RD_ADDR: begin
                            RXCont_command   <= CMD_RD;
                            RXCont_Addr      <= RXCont_P_Data;
                            RXCont_Pdata     <= '0;
                            RXCont_Cmd_Valid <= 1'b1;
                            state            <= PEND;
                        end
                        OP_A: begin
                            RXCont_command   <= CMD_OPND;
                            RXCont_Addr      <= OPA_ADDR;
                            RXCont_Pdata     <= RXCont_P_Data;
                            RXCont_Cmd_Valid <= 1'b1;
                            state            <= OP_B;
                        end
                        OP_B: begin
                            RXCont_command   <= CMD_OPND;
                            RXCont_Addr      <= OPB_ADDR;
                            RXCont_Pdata     <= RXCont_P_Data;
                            RXCont_Cmd_Valid <= 1'b1;
                            state            <= ALU_FUN;
                        end
                        ALU_FUN: begin
                            RXCont_command   <= CMD_ALU;
                            RXCont_Addr      <= '0;
                            RXCont_Pdata     <= {{(DATA_WIDTH-4){1'b0}}, RXCont_P_Data[3:0]};
                            RXCont_Cmd_Valid <= 1'b1;
                            state            <= PEND;
                        end
                        default: state <= IDLE;
                    endcase
                end
            end else if (tmo_active) begin
                if (tmo_cnt == TMO_LAST) begin
                    tmo_cnt          <= '0;
                    state            <= IDLE;
                    RXCont_Frame_Err <= 1'b1;
                end else begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                end
            end else begin
                tmo_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_rx_controller.sv
// Scoreboard bench for rx_controller: stimulus pushes expected commands,
// a negedge monitor pops and compares on every accepted command.
module tb_rx_controller;

    localparam int unsigned TIMEOUT = 1024;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] p_data = 8'h00;
    logic       dv = 1'b0;
    logic       ready = 1'b1;
    logic [2:0] command;
    logic [7:0] addr;
    logic [7:0] pdata;
    logic       cmd_valid;
    logic       frame_err;

    int checks = 0;
    int failures = 0;
    int err_cnt = 0;
    int acc_cnt = 0;

    logic [18:0] exp_q[$];
    logic [18:0] held;
    logic        held_v = 1'b0;

    rx_controller #(.DATA_WIDTH(8), .TIMEOUT(TIMEOUT)) dut (
        .RXCont_CLK        (clk),
        .RXCont_RST        (rst_n),
        .RXCont_P_Data     (p_data),
        .RXCont_Data_Valid (dv),
        .RXCont_Ready      (ready),
        .RXCont_command    (command),
        .RXCont_Addr       (addr),
        .RXCont_Pdata      (pdata),
        .RXCont_Cmd_Valid  (cmd_valid),
        .RXCont_Frame_Err  (frame_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        p_data = b;
        dv     = 1'b1;
        tick();
        dv     = 1'b0;
    endtask

    // Monitor: count error pulses, check held fields, pop on acceptance.
    always @(negedge clk) begin
        if (!rst_n) begin
            held_v = 1'b0;
        end else begin
            if (frame_err) err_cnt++;
            if (cmd_valid) begin
                if (held_v) check("hold_fields", {13'd0, command, addr, pdata}, {13'd0, held});
                if (ready) begin
                    acc_cnt++;
                    held_v = 1'b0;
                    if (exp_q.size() == 0) begin
                        check("unexpected_cmd", {13'd0, command, addr, pdata}, 32'hFFFFFFFF);
                    end else begin
                        check("cmd_fields", {13'd0, command, addr, pdata},
                              {13'd0, exp_q.pop_front()});
                    end
                end else begin
                    held_v = 1'b1;
                    held   = {command, addr, pdata};
                end
            end else begin
                held_v = 1'b0;
            end
        end
    end

    initial begin
        int e0;
        int a0;
        int n;

        // Reset state
        repeat (3) tick();
        check("rst_cmd_valid", {31'd0, cmd_valid}, 32'd0);
        check("rst_command", {29'd0, command}, 32'd0);
        check("rst_addr", {24'd0, addr}, 32'd0);
        check("rst_pdata", {24'd0, pdata}, 32'd0);
        check("rst_frame_err", {31'd0, frame_err}, 32'd0);
        rst_n = 1'b1;
        repeat (2) tick();

        // 1: register write, latency one cycle after the final strobe
        a0 = acc_cnt;
        exp_q.push_back({3'b001, 8'h05, 8'h3C});
        send_byte(8'hAA);
        send_byte(8'h05);
        check("t1_no_early_valid", {31'd0, cmd_valid}, 32'd0);
        send_byte(8'h3C);
        check("t1_valid_latency", {31'd0, cmd_valid}, 32'd1);
        repeat (3) tick();
        check("t1_single_accept", acc_cnt - a0, 32'd1);

        // 2: read held while not ready
        exp_q.push_back({3'b010, 8'h07, 8'h00});
        send_byte(8'hBB);
        ready = 1'b0;
        send_byte(8'h07);
        check("t2_valid", {31'd0, cmd_valid}, 32'd1);
        check("t2_command", {29'd0, command}, 32'd2);
        check("t2_addr", {24'd0, addr}, 32'h07);
        repeat (5) tick();
        check("t2_still_valid", {31'd0, cmd_valid}, 32'd1);
        ready = 1'b1;
        tick();
        check("t2_valid_drop", {31'd0, cmd_valid}, 32'd0);
        check("t2_command_none", {29'd0, command}, 32'd0);

        // 3: ALU frame with operands, back-to-back bytes
        a0 = acc_cnt;
        exp_q.push_back({3'b011, 8'h00, 8'h12});
        exp_q.push_back({3'b011, 8'h01, 8'h34});
        exp_q.push_back({3'b100, 8'h00, 8'h01});
        send_byte(8'hCC);
        send_byte(8'h12);
        send_byte(8'h34);
        send_byte(8'hF1);
        repeat (3) tick();
        check("t3_accepts", acc_cnt - a0, 32'd3);

        // 4a: bad opcode
        e0 = err_cnt;
        a0 = acc_cnt;
        send_byte(8'h55);
        check("t4_err_pulse_now", {31'd0, frame_err}, 32'd1);
        tick();
        check("t4_err_one_cycle", {31'd0, frame_err}, 32'd0);
        repeat (2) tick();
        check("t4_err_count", err_cnt - e0, 32'd1);
        check("t4_no_cmd", acc_cnt - a0, 32'd0);

        // 4b: timeout after partial write frame
        e0 = err_cnt;
        send_byte(8'hAA);
        send_byte(8'h09);
        n = 0;
        while (!frame_err && n < TIMEOUT + 20) begin
            tick();
            n++;
        end
        check("t4_timeout_cycles", n, TIMEOUT);
        repeat (3) tick();
        check("t4_timeout_err_count", err_cnt - e0, 32'd1);
        check("t4_timeout_no_cmd", acc_cnt - a0, 32'd0);
        // FSM must be back in IDLE: a read frame decodes as such
        exp_q.push_back({3'b010, 8'h11, 8'h00});
        send_byte(8'hBB);
        send_byte(8'h11);
        repeat (2) tick();

        // 5: overrun while a read is pending
        e0 = err_cnt;
        a0 = acc_cnt;
        exp_q.push_back({3'b010, 8'h02, 8'h00});
        ready = 1'b0;
        send_byte(8'hBB);
        send_byte(8'h02);
        tick();
        send_byte(8'hAA);
        repeat (2) tick();
        check("t5_overrun_err", err_cnt - e0, 32'd1);
        check("t5_still_pending", {31'd0, cmd_valid}, 32'd1);
        ready = 1'b1;
        repeat (2) tick();
        check("t5_accepted", acc_cnt - a0, 32'd1);
        exp_q.push_back({3'b010, 8'h03, 8'h00});
        send_byte(8'hBB);
        send_byte(8'h03);
        repeat (2) tick();
        check("t5_idle_after", acc_cnt - a0, 32'd2);

        // 6: reset mid-frame and with a pending command
        ready = 1'b0;
        send_byte(8'hBB);
        send_byte(8'h44);
        rst_n = 1'b0;
        #1;
        check("t6_rst_valid", {31'd0, cmd_valid}, 32'd0);
        check("t6_rst_command", {29'd0, command}, 32'd0);
        check("t6_rst_addr", {24'd0, addr}, 32'd0);
        tick();
        rst_n = 1'b1;
        ready = 1'b1;
        tick();
        send_byte(8'hAA);
        send_byte(8'h05);
        rst_n = 1'b0;
        #1;
        check("t6_rst2_outputs", {18'd0, cmd_valid, frame_err, command, addr}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        a0 = acc_cnt;
        exp_q.push_back({3'b100, 8'h00, 8'h03});
        send_byte(8'hDD);
        send_byte(8'h03);
        repeat (3) tick();
        check("t6_alu_accept", acc_cnt - a0, 32'd1);

        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
